// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch (I) and data (D) ports onto one single-port RAM, with a per-access watchdog.
// Optional ARB_ROUND_ROBIN_EN macro: round-robin ties instead of fixed D priority.
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 20,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TO_CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ready,
  input  logic                  d_valid,
  input  logic [3:0]            d_wstrb,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  mem_valid,
  output logic [3:0]            mem_wstrb,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  bus_err,
  output logic                  grant_d
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  localparam logic [TO_CNT_WIDTH-1:0] TimeoutVal = TO_CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam bit WdogEn = (TIMEOUT_CYCLES != 0);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [3:0]              wstrb_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [TO_CNT_WIDTH-1:0] cnt_q;
  logic                    err_q;
  logic                    grant_d_q;
  logic                    last_grant_q;  // 1 = D
  logic                    mem_valid_q;
  logic                    i_ready_q;
  logic                    d_ready_q;
  logic                    pick_d;

  always_comb begin
    pick_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, the port that did not win last time gets the grant.
    pick_d = d_valid && (!i_valid || !last_grant_q);
`else
    pick_d = d_valid;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      grant_d_q    <= 1'b0;
      last_grant_q <= 1'b0;
      mem_valid_q  <= 1'b0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_valid || d_valid) begin
            grant_d_q   <= pick_d;
            addr_q      <= pick_d ? d_addr  : i_addr;
            wstrb_q     <= pick_d ? d_wstrb : 4'b0000;
            wdata_q     <= pick_d ? d_wdata : '0;
            cnt_q       <= '0;
            mem_valid_q <= 1'b1;
            state_q     <= StBusy;
          end
        end
        StBusy: begin
          if (mem_ready) begin
            rdata_q     <= mem_rdata;
            mem_valid_q <= 1'b0;
            i_ready_q   <= !grant_d_q;
            d_ready_q   <= grant_d_q;
            state_q     <= StResp;
          end else if (WdogEn && (cnt_q == TimeoutVal)) begin
            rdata_q     <= '0;
            err_q       <= 1'b1;
            mem_valid_q <= 1'b0;
            i_ready_q   <= !grant_d_q;
            d_ready_q   <= grant_d_q;
            state_q     <= StResp;
          end else if (WdogEn) begin
            cnt_q <= cnt_q + TO_CNT_WIDTH'(1);
          end
        end
        StResp: begin
          i_ready_q    <= 1'b0;
          d_ready_q    <= 1'b0;
          err_q        <= 1'b0;
          cnt_q        <= '0;
          last_grant_q <= grant_d_q;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = addr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_rdata   = i_ready_q ? rdata_q : '0;
  assign d_rdata   = d_ready_q ? rdata_q : '0;
  assign bus_err   = err_q;
  // In IDLE the status reflects the last completed grant; otherwise the in-flight one.
  assign grant_d   = (state_q == StIdle) ? last_grant_q : grant_d_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a same-cycle RAM model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [19:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_valid;
  logic [3:0]  d_wstrb;
  logic [19:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_valid;
  logic [3:0]  mem_wstrb;
  logic [19:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_err;
  logic        grant_d;
  logic        ready_en;

  int checks = 0;
  int failures = 0;

  logic [31:0] ram [0:1023];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(20), .TIMEOUT_CYCLES(4), .TO_CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_valid(d_valid), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_valid(mem_valid), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_err(bus_err), .grant_d(grant_d)
  );

  assign mem_ready = mem_valid & ready_en;
  assign mem_rdata = ram[mem_addr[9:0]];

  always @(posedge clk) begin
    if (mem_valid && mem_ready) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wstrb[b]) ram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic d_acc(input logic [3:0] s, input logic [19:0] a, input logic [31:0] w,
                       input bit chk_r, input logic [31:0] exp_r, input string tag);
    d_valid = 1'b1; d_wstrb = s; d_addr = a; d_wdata = w;
    tick();
    chk({tag, "_mem_valid"}, mem_valid, 1);
    chk({tag, "_mem_wstrb"}, mem_wstrb, s);
    chk({tag, "_mem_addr"}, mem_addr, a);
    chk({tag, "_grant_d"}, grant_d, 1);
    tick();
    chk({tag, "_d_ready"}, d_ready, 1);
    chk({tag, "_i_ready"}, i_ready, 0);
    chk({tag, "_busy_off"}, mem_valid, 0);
    if (chk_r) chk({tag, "_d_rdata"}, d_rdata, exp_r);
    d_valid = 1'b0; d_wstrb = 4'b0000;
    tick();
    chk({tag, "_d_ready_drop"}, d_ready, 0);
  endtask

  initial begin
    bit [3:0] exp_order;
    rst = 1'b1; ready_en = 1'b1;
    i_valid = 1'b0; i_addr = '0;
    d_valid = 1'b0; d_wstrb = '0; d_addr = '0; d_wdata = '0;
    tick(); tick();
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_i_ready", i_ready, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_grant_d", grant_d, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;
    tick();

    // Preload through the D port
    d_acc(4'b1111, 20'h100, 32'hDEADBEEF, 1'b0, 32'h0, "pre100");
    d_acc(4'b1111, 20'h040, 32'hFFFFFFFF, 1'b0, 32'h0, "pre040");

    // Fetch read, idle D port presenting full strobes
    i_valid = 1'b1; i_addr = 20'h100; d_wstrb = 4'b1111; d_addr = 20'h3FF;
    tick();
    chk("fetch_mem_valid", mem_valid, 1);
    chk("fetch_mem_wstrb", mem_wstrb, 0);
    chk("fetch_mem_addr", mem_addr, 20'h100);
    chk("fetch_grant_d", grant_d, 0);
    tick();
    chk("fetch_i_ready", i_ready, 1);
    chk("fetch_i_rdata", i_rdata, 32'hDEADBEEF);
    chk("fetch_d_ready", d_ready, 0);
    chk("fetch_d_rdata", d_rdata, 0);
    chk("fetch_bus_err", bus_err, 0);
    i_valid = 1'b0; d_wstrb = 4'b0000;
    tick();
    chk("fetch_i_ready_drop", i_ready, 0);
    chk("fetch_idle_mem_valid", mem_valid, 0);

    // Partial write then read-back
    d_acc(4'b0011, 20'h040, 32'h11223344, 1'b0, 32'h0, "pwr");
    d_acc(4'b0000, 20'h040, 32'h0, 1'b1, 32'hFFFF3344, "prd");

    // Simultaneous requests, starting from reset so last_grant=I
    rst = 1'b1; tick(); rst = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = 4'b0101;
`else
    exp_order = 4'b1111;
`endif
    i_valid = 1'b1; i_addr = 20'h100;
    d_valid = 1'b1; d_addr = 20'h040; d_wstrb = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("tie%0d_grant_d", k), grant_d, exp_order[k]);
      tick();
      chk($sformatf("tie%0d_d_ready", k), d_ready, exp_order[k]);
      chk($sformatf("tie%0d_i_ready", k), i_ready, !exp_order[k]);
      if (exp_order[k]) chk($sformatf("tie%0d_rdata", k), d_rdata, 32'hFFFF3344);
      else              chk($sformatf("tie%0d_rdata", k), i_rdata, 32'hDEADBEEF);
      tick();
    end
    d_valid = 1'b0;
    tick();
    chk("tie_after_grant_d", grant_d, 0);
    tick();
    chk("tie_after_i_ready", i_ready, 1);
    chk("tie_after_i_rdata", i_rdata, 32'hDEADBEEF);
    i_valid = 1'b0;
    tick();

    // Watchdog: RAM never answers
    ready_en = 1'b0;
    d_valid = 1'b1; d_addr = 20'h040; d_wstrb = 4'b0000;
    tick();
    chk("wd_busy_n1", mem_valid, 1);
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk($sformatf("wd_no_ready_n%0d", k), d_ready, 0);
      chk($sformatf("wd_mem_valid_n%0d", k), mem_valid, 1);
    end
    tick();
    chk("wd_d_ready", d_ready, 1);
    chk("wd_bus_err", bus_err, 1);
    chk("wd_d_rdata", d_rdata, 0);
    chk("wd_mem_valid", mem_valid, 0);
    d_valid = 1'b0; ready_en = 1'b1;
    tick();
    chk("wd_d_ready_drop", d_ready, 0);
    chk("wd_bus_err_drop", bus_err, 0);

    // Reset in the BUSY cycle
    d_valid = 1'b1; d_addr = 20'h080; d_wstrb = 4'b1111; d_wdata = 32'hCAFEF00D;
    tick();
    chk("rmid_busy", mem_valid, 1);
    rst = 1'b1;
    tick();
    chk("rmid_mem_valid", mem_valid, 0);
    chk("rmid_d_ready", d_ready, 0);
    chk("rmid_bus_err", bus_err, 0);
    chk("rmid_grant_d", grant_d, 0);
    chk("rmid_mem_addr", mem_addr, 0);
    rst = 1'b0; d_valid = 1'b0; d_wstrb = 4'b0000;
    tick();
    chk("rmid_no_late_ready", d_ready, 0);
    d_acc(4'b0000, 20'h040, 32'h0, 1'b1, 32'hFFFF3344, "rmid_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port word-indexed RAM between the core's instruction-fetch (I) and data (D) requesters.
- Captures one request at a time into holding registers, drives the RAM valid/ready interface, then returns registered read data and a one-cycle ready pulse to the granted requester.
- Includes a per-access watchdog that aborts hung transfers with an error pulse.
- Sits between riscv_top's two memory ports and the RAM model.

Parameters:
- DATA_WIDTH, 32, word width of all data buses
- ADDR_WIDTH, 20, word-index address width (byte address bits [ADDR_WIDTH+1:2])
- TIMEOUT_CYCLES, 16, BUSY cycles without mem_ready before abort; 0 disables the watchdog
- TO_CNT_WIDTH, 8, watchdog counter width; must hold TIMEOUT_CYCLES

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- i_valid  input  1  fetch request; held until i_ready is seen
- i_addr  input  ADDR_WIDTH  fetch word index
- i_rdata  output  DATA_WIDTH  fetch read data, valid while i_ready=1
- i_ready  output  1  one-cycle completion pulse to fetch
- d_valid  input  1  data request; held until d_ready is seen
- d_wstrb  input  4  byte write strobes; 0 = read
- d_addr  input  ADDR_WIDTH  data word index
- d_wdata  input  DATA_WIDTH  write data
- d_rdata  output  DATA_WIDTH  data read data, valid while d_ready=1
- d_ready  output  1  one-cycle completion pulse to data
- mem_valid  output  1  RAM request
- mem_wstrb  output  4  RAM strobes
- mem_addr  output  ADDR_WIDTH  RAM word index
- mem_wdata  output  DATA_WIDTH  RAM write data
- mem_rdata  input  DATA_WIDTH  RAM read data (combinational in RAM)
- mem_ready  input  1  RAM completion (may be same-cycle as mem_valid)
- bus_err  output  1  one-cycle pulse coincident with the aborted requester's ready
- grant_d  output  1  1 when current/last grant is D (status)

Behaviour:
- Reset, and every synchronous rst cycle: state=IDLE. All outputs 0. Holding registers 0. Watchdog counter 0. last_grant=I.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any valid, arbitrate, latch the winner's addr/wstrb/wdata into holding registers and set grant_d. Go to BUSY. Otherwise stay.
  - I requests are latched with wstrb forced to 4'b0000.
- BUSY:
  - mem_valid=1. mem_addr/mem_wstrb/mem_wdata driven only from the holding registers, never from requester inputs.
  - On mem_ready=1: latch mem_rdata (writes latch the echoed value) into rdata_q. Go to RESP.
  - Otherwise increment the watchdog counter.
  - If the counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES≠0): rdata_q=0, set err_q. Go to RESP.
- RESP:
  - mem_valid=0. Granted requester's ready=1 for exactly one cycle, its rdata=rdata_q. bus_err=err_q.
  - Non-granted port: ready=0, rdata=0.
  - Update last_grant, clear counter and err_q. Go to IDLE.
- Latency:
  - Request first seen in IDLE at cycle N → mem_valid at N+1 → with a same-cycle RAM, ready at N+2.
  - Minimum 3 cycles per access. Back-to-back requests from one port: 3-cycle spacing.
- Requesters must drop or replace valid the cycle after ready. A valid still high in the following IDLE cycle is a new request.
- A requester dropping valid during BUSY does not cancel the RAM access; ready is still pulsed.
- Reset asserted in BUSY or RESP: abort immediately. No ready pulse, mem_valid=0 next cycle. The in-flight write may or may not have reached RAM.
- Only one of i_ready/d_ready is ever high. mem_valid is never high in IDLE or RESP.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when i_valid and d_valid are both high in IDLE, grant the port not equal to last_grant. After reset (last_grant=I), D wins the first tie.
- Undefined: fixed priority, D always wins ties. last_grant is still kept, only for grant_d status.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Fetch read: preload word 0x100 = 0xDEADBEEF; i_valid, i_addr=0x100 → mem_valid at N+1 with wstrb=0; i_ready pulse at N+2 with i_rdata=0xDEADBEEF.
- Partial write then read:
  - D write addr 0x40, wdata 0x11223344, wstrb 4'b0011 over word 0xFFFFFFFF → d_ready at N+2.
  - Following D read → d_rdata=0xFFFF3344.
- Simultaneous requests: i_valid and d_valid held high for 4 accesses.
  - With ARB_ROUND_ROBIN_EN: grant order D, I, D, I.
  - Without: D, D, D, D while d_valid stays high; I served only after d_valid drops.
- Fetch wstrb forcing: i_valid with d_wstrb=4'b1111 on an idle D port → mem_wstrb=0 during BUSY.
- Watchdog: TIMEOUT_CYCLES=4, mem_ready tied 0 → d_ready and bus_err both high at N+6, d_rdata=0, then IDLE.
- Reset mid-op: assert rst in the BUSY cycle → no d_ready pulse ever; next cycle all outputs 0, state IDLE; a new request after deassert completes normally.
